control_unit: RTL
=================

Name: control_unit

Overview:
Multi-cycle FSM controller for the K&S processor. It sits directly beside data_path and consumes data_path's decoded_instruction and registered flags. It drives every data_path control input plus the RAM write strobe. It sequences fetch, decode and execute one instruction at a time, and it counts retired instructions.

Parameters:
COUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
decoded_instruction  input  decoded_instruction_type  instruction class from data_path; valid from the cycle after the IR load.
zero_op  input  1  registered zero flag.
neg_op  input  1  registered negative flag.
unsigned_overflow  input  1  registered unsigned-overflow flag.
signed_overflow  input  1  registered signed-overflow flag.
branch  output  1  selects mem_addr as the next PC; otherwise the next PC is PC+1.
pc_enable  output  1  PC update strobe.
ir_enable  output  1  IR load strobe.
addr_sel  output  1  RAM address select: 0 = PC, 1 = instruction mem_addr.
c_sel  output  1  register write-data select: 0 = ALU, 1 = data_in.
operation  output  2  ALU operation: 00 add, 01 and, 10 or, 11 sub.
write_reg_enable  output  1  register-file write strobe.
flags_reg_enable  output  1  flag-register update strobe.
ram_write_enable  output  1  RAM write strobe; address is given by addr_sel, data is data_out.
halt  output  1  high while the processor is halted.
instr_count  output  COUNT_W  number of retired instructions; saturates.

Behaviour:
- Reset: rst is asynchronous and active-high.
  - State goes to FETCH and instr_count goes to 0.
  - While rst is high, all strobes (pc_enable, ir_enable, write_reg_enable, flags_reg_enable, ram_write_enable, branch) are 0; addr_sel, c_sel, operation and halt are 0.
- Output decode: outputs are Moore-decoded from state, except BRANCH_EVAL, where pc_enable and branch also depend on decoded_instruction and the flags. Any output not listed for a state is 0.
- RAM timing: the RAM has 1-cycle synchronous read latency.
- FETCH: addr_sel=0. Next state: LOAD_IR.
- LOAD_IR: addr_sel=0, ir_enable=1. Next state: DECODE.
- DECODE: pc_enable=1, branch=0 (PC+1). Dispatch on decoded_instruction:
  - I_NOP -> FETCH.
  - I_LOAD -> LOAD_ADDR.
  - I_STORE -> STORE_WR.
  - I_MOVE -> MOVE_EXEC.
  - I_ADD, I_SUB, I_AND, I_OR -> ALU_EXEC.
  - I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO -> BRANCH_EVAL.
  - I_HALT -> HALT.
  - Any other encoding is treated as I_NOP.
- LOAD_ADDR: addr_sel=1. Next state: LOAD_WB.
- LOAD_WB: addr_sel=1, c_sel=1, write_reg_enable=1. Flags are not updated. Next state: FETCH.
- STORE_WR: addr_sel=1, ram_write_enable=1 for exactly one cycle. Next state: FETCH.
- MOVE_EXEC: operation=10 (a|a passes a), c_sel=0, write_reg_enable=1, flags_reg_enable=0. Next state: FETCH.
- ALU_EXEC: c_sel=0, write_reg_enable=1, flags_reg_enable=1. Operation: ADD->00, AND->01, OR->10, SUB->11. Next state: FETCH.
- BRANCH_EVAL: if the condition is true, pc_enable=1 and branch=1. Next state is FETCH in both cases. Conditions:
  - BRANCH: always.
  - BZERO: zero_op. BNZERO: !zero_op.
  - BNEG: neg_op. BNNEG: !neg_op.
  - BOV: signed_overflow. BNOV: !signed_overflow.
  - When not taken, PC keeps the DECODE-cycle increment.
- HALT: halt=1, all strobes 0. Remains in HALT until rst.
- Latency in cycles, measured FETCH to next FETCH:
  - NOP: 3.
  - STORE, MOVE, ALU, branch: 4.
  - LOAD: 5.
- instr_count:
  - Increments by 1 on the cycle the FSM returns to FETCH from any execute state, and when DECODE dispatches I_NOP.
  - Increments once on entering HALT; does not increment while in HALT.
  - Saturates at 2^COUNT_W-1 with no wrap.
- Reset mid-instruction: aborts immediately. No strobe may stay high in the same cycle rst is asserted, because reset is asynchronous and outputs are decoded from the reset state.
- Flags are sampled only in BRANCH_EVAL. A flag update from an ALU_EXEC is visible to a branch that immediately follows it.

Test Plan:
1. Reset, then release; decoded_instruction=I_NOP held -> state cycle FETCH, LOAD_IR, DECODE repeats; pc_enable pulses once every 3 cycles; instr_count=1, 2, 3 after each pulse.
2. I_ADD -> exactly one ALU_EXEC cycle with operation=00, write_reg_enable=1, flags_reg_enable=1. Repeat with I_SUB -> operation=11. Repeat with I_MOVE -> operation=10 and flags_reg_enable=0.
3. I_LOAD -> addr_sel=1 for 2 cycles; c_sel=1 and write_reg_enable=1 only in the second. I_STORE -> ram_write_enable=1 for exactly 1 cycle with addr_sel=1.
4. I_BZERO with zero_op=1 -> BRANCH_EVAL drives pc_enable=1 and branch=1. With zero_op=0 -> both 0. Repeat for BNNEG (neg_op=0 taken) and BOV (signed_overflow=1 taken).
5. I_HALT -> halt=1 held for 20+ cycles, all strobes 0, instr_count frozen. Assert rst -> halt=0 and state=FETCH asynchronously.
6. Assert rst during LOAD_WB -> write_reg_enable drops in the same cycle; instr_count=0. Separately, force instr_count to saturate with COUNT_W=4 -> it stops at 15.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute FSM driving the K&S data_path
package control_unit_pkg;
   typedef enum logic [3:0] {
      I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
      I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
   } decoded_instruction_type;
endpackage

module control_unit import control_unit_pkg::*; #(
   parameter int COUNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [COUNT_W-1:0]      instr_count
);
   typedef enum logic [3:0] {
      FETCH, LOAD_IR, DECODE, LOAD_ADDR, LOAD_WB, STORE_WR, MOVE_EXEC, ALU_EXEC, BRANCH_EVAL, HALT
   } state_t;

   state_t state, next_state;
   logic   taken, retire;
   logic   unused_flag;

   // no branch condition looks at unsigned overflow
   assign unused_flag = unsigned_overflow;

   // branch condition from the registered flags
   always_comb begin
      taken = 1'b0;
      case (decoded_instruction)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero_op;
         I_BNZERO: taken = !zero_op;
         I_BNEG:   taken = neg_op;
         I_BNNEG:  taken = !neg_op;
         I_BOV:    taken = signed_overflow;
         I_BNOV:   taken = !signed_overflow;
         default:  taken = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   // next state and Moore outputs; BRANCH_EVAL also looks at the condition
   always_comb begin
      next_state       = state;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      case (state)
         FETCH: next_state = LOAD_IR;
         LOAD_IR: begin
            ir_enable  = 1'b1;
            next_state = DECODE;
         end
         DECODE: begin
            pc_enable = 1'b1;
            case (decoded_instruction)
               I_LOAD:  next_state = LOAD_ADDR;
               I_STORE: next_state = STORE_WR;
               I_MOVE:  next_state = MOVE_EXEC;
               I_ADD, I_SUB, I_AND, I_OR: next_state = ALU_EXEC;
               I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO: next_state = BRANCH_EVAL;
               I_HALT:  next_state = HALT;
               default: next_state = FETCH;
            endcase
         end
         LOAD_ADDR: begin
            addr_sel   = 1'b1;
            next_state = LOAD_WB;
         end
         LOAD_WB: begin
            addr_sel         = 1'b1;
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
            next_state       = FETCH;
         end
         STORE_WR: begin
            addr_sel         = 1'b1;
            ram_write_enable = 1'b1;
            next_state       = FETCH;
         end
         MOVE_EXEC: begin
            operation        = 2'b10;
            write_reg_enable = 1'b1;
            next_state       = FETCH;
         end
         ALU_EXEC: begin
            operation        = decoded_instruction == I_AND ? 2'b01 :
                               decoded_instruction == I_OR  ? 2'b10 :
                               decoded_instruction == I_SUB ? 2'b11 : 2'b00;
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            next_state       = FETCH;
         end
         BRANCH_EVAL: begin
            pc_enable  = taken;
            branch     = taken;
            next_state = FETCH;
         end
         HALT: halt = 1'b1;
         default: next_state = FETCH;
      endcase
   end

   // an instruction retires whenever the FSM lands in FETCH or first enters HALT
   assign retire = (next_state == FETCH || next_state == HALT) && state != HALT;

   // saturating retired-instruction counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             instr_count <= '0;
      else if (retire && instr_count != '1) instr_count <= instr_count + COUNT_W'(1);
   end
endmodule
